register_file: RTL and testbench

Parametrised multi-register storage block: the successor to the single 32-bit enable-loaded register used in the datapath. It has one write port with byte-lane enables and two independent read ports with registered outputs. Same-cycle write-to-read bypass and a per-register "written since clear" flag are included. It sits between the datapath bus and the ALU operand latches and replaces banks of individually instantiated registers.

---
 rtl/register_file.sv | 127 ++++++++++++
 tb/tb_register_file.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// Multi-register storage with one byte-lane-masked write port and two registered
// read ports; same-edge write-to-read bypass and per-register "written since clear" flags.
module register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter bit ZERO_REG = 1'b1,
  localparam int AW = $clog2(DEPTH),
  localparam int NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [NB-1:0]    wbe,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re_a,
  input  logic [AW-1:0]    raddr_a,
  output logic [WIDTH-1:0] rdata_a,
  output logic             rvalid_a,
  output logic             rinit_a,
  input  logic             re_b,
  input  logic [AW-1:0]    raddr_b,
  output logic [WIDTH-1:0] rdata_b,
  output logic             rvalid_b,
  output logic             rinit_b
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [DEPTH-1:0] init_q;

  logic             wr_ok;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_merged;

  // Port 0 is A, port 1 is B; both ports share one piece of read logic.
  logic [1:0]       re_v;
  logic [AW-1:0]    raddr_v [2];
  logic [WIDTH-1:0] rd_next [2];
  logic [1:0]       ri_next;
  logic [WIDTH-1:0] rdata_q [2];
  logic [1:0]       rvalid_q;
  logic [1:0]       rinit_q;

  function automatic logic is_legal(input logic [AW-1:0] a);
    return int'(a) < DEPTH;
  endfunction

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] merge_lanes(input logic [WIDTH-1:0] old_word,
                                                   input logic [WIDTH-1:0] new_word,
                                                   input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign re_v       = {re_b, re_a};
  assign raddr_v[0] = raddr_a;
  assign raddr_v[1] = raddr_b;

  // Writes to out-of-range addresses or to a hard-wired zero register are dropped.
  assign wr_ok     = we && is_legal(waddr) && !is_zero_reg(waddr);
  assign wr_old    = is_legal(waddr) ? mem[waddr] : '0;
  assign wr_merged = merge_lanes(wr_old, wdata, wbe);

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_next[p] = '0;
      ri_next[p] = 1'b0;
      if (is_legal(raddr_v[p])) begin
        if (is_zero_reg(raddr_v[p])) begin
          ri_next[p] = 1'b1;
        end else if (wr_ok && (raddr_v[p] == waddr)) begin
          rd_next[p] = wr_merged;
          ri_next[p] = 1'b1;
        end else begin
          rd_next[p] = mem[raddr_v[p]];
          ri_next[p] = init_q[raddr_v[p]];
        end
      end
    end
  end

  // NOTE: the storage array is reset on purpose -- a clear must make every register read 0.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      init_q <= '0;
    end else if (wr_ok) begin
      // NOTE: non-blocking assignments keep reads on this edge seeing pre-write state.
      mem[waddr]    <= wr_merged;
      init_q[waddr] <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
      rvalid_q   <= '0;
      rinit_q    <= '0;
    end else begin
      rvalid_q <= re_v;
      for (int p = 0; p < 2; p++) begin
        if (re_v[p]) begin
          rdata_q[p] <= rd_next[p];
          rinit_q[p] <= ri_next[p];
        end
      end
    end
  end

  assign rdata_a  = rdata_q[0];
  assign rvalid_a = rvalid_q[0];
  assign rinit_a  = rinit_q[0];
  assign rdata_b  = rdata_q[1];
  assign rvalid_b = rvalid_q[1];
  assign rinit_b  = rinit_q[1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: two DEPTH=10 instances sharing stimulus,
// one with the zero register enabled and one without.
module tb_register_file;

  localparam int WIDTH = 32;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             clr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [3:0]       wbe;
  logic [WIDTH-1:0] wdata;
  logic             re_a, re_b;
  logic [AW-1:0]    raddr_a, raddr_b;

  logic [WIDTH-1:0] rdata_a, rdata_b, z0_rdata_a, z0_rdata_b;
  logic             rvalid_a, rvalid_b, rinit_a, rinit_b;
  logic             z0_rvalid_a, z0_rvalid_b, z0_rinit_a, z0_rinit_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  register_file #(.WIDTH(WIDTH), .DEPTH(10), .ZERO_REG(1'b1)) dut (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a), .rvalid_a(rvalid_a), .rinit_a(rinit_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b), .rvalid_b(rvalid_b), .rinit_b(rinit_b)
  );

  register_file #(.WIDTH(WIDTH), .DEPTH(10), .ZERO_REG(1'b0)) dut_z0 (
    .clk(clk), .clr(clr), .we(we), .waddr(waddr), .wbe(wbe), .wdata(wdata),
    .re_a(re_a), .raddr_a(raddr_a), .rdata_a(z0_rdata_a), .rvalid_a(z0_rvalid_a), .rinit_a(z0_rinit_a),
    .re_b(re_b), .raddr_b(raddr_b), .rdata_b(z0_rdata_b), .rvalid_b(z0_rvalid_b), .rinit_b(z0_rinit_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it, where outputs are sampled and inputs changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] d;

    clr = 1'b1; we = 1'b0; waddr = '0; wbe = '0; wdata = '0;
    re_a = 1'b0; re_b = 1'b0; raddr_a = '0; raddr_b = '0;
    step();
    step();
    clr = 1'b0;
    step();
    check("reset rdata_a", rdata_a, 32'h0);
    check("reset rvalid_a", 32'(rvalid_a), 32'h0);
    check("reset rinit_a", 32'(rinit_a), 32'h0);
    check("reset rdata_b", rdata_b, 32'h0);

    // Full write then a single-lane overwrite of r3.
    we = 1'b1; waddr = 4'd3; wbe = 4'b1111; wdata = 32'hDEADBEEF;
    step();
    wbe = 4'b0100; wdata = 32'h00AA0000;
    step();
    we = 1'b0; re_a = 1'b1; raddr_a = 4'd3;
    step();
    check("lane rdata_a", rdata_a, 32'hDEAABEEF);
    check("lane rinit_a", 32'(rinit_a), 32'h1);
    check("lane rvalid_a", 32'(rvalid_a), 32'h1);
    re_a = 1'b0;
    step();
    check("pulse rvalid_a low", 32'(rvalid_a), 32'h0);
    check("hold rdata_a", rdata_a, 32'hDEAABEEF);

    // Bypass: full write to r5 read on both ports on the same edge.
    we = 1'b1; waddr = 4'd5; wbe = 4'b1111; wdata = 32'h12345678;
    re_a = 1'b1; raddr_a = 4'd5; re_b = 1'b1; raddr_b = 4'd5;
    step();
    check("bypass rdata_a", rdata_a, 32'h12345678);
    check("bypass rdata_b", rdata_b, 32'h12345678);
    check("bypass rinit_a", 32'(rinit_a), 32'h1);
    check("bypass rinit_b", 32'(rinit_b), 32'h1);
    check("bypass rvalid_b", 32'(rvalid_b), 32'h1);

    // Partial bypass: only lane 0 of r3 replaced, others come from storage.
    waddr = 4'd3; wbe = 4'b0001; wdata = 32'hFFFFFF11;
    raddr_a = 4'd3; re_b = 1'b0;
    step();
    check("partial bypass rdata_a", rdata_a, 32'hDEAABE11);
    check("re_b low rvalid_b", 32'(rvalid_b), 32'h0);

    // Zero register: dropped on one instance, stored on the other.
    waddr = 4'd0; wbe = 4'b1111; wdata = 32'hFFFFFFFF; re_a = 1'b0;
    step();
    we = 1'b0; re_a = 1'b1; raddr_a = 4'd0;
    step();
    check("zero_reg rdata_a", rdata_a, 32'h0);
    check("zero_reg rinit_a", 32'(rinit_a), 32'h1);
    check("no zero_reg rdata_a", z0_rdata_a, 32'hFFFFFFFF);
    check("no zero_reg rinit_a", 32'(z0_rinit_a), 32'h1);

    // Illegal address 12 (DEPTH=10): write dropped, read returns zero with valid.
    we = 1'b1; waddr = 4'd12; wbe = 4'b1111; wdata = 32'h00000055; re_a = 1'b0;
    step();
    we = 1'b0; re_a = 1'b1; raddr_a = 4'd12; re_b = 1'b1; raddr_b = 4'd4;
    step();
    check("illegal rdata_a", rdata_a, 32'h0);
    check("illegal rinit_a", 32'(rinit_a), 32'h0);
    check("illegal rvalid_a", 32'(rvalid_a), 32'h1);
    check("illegal z0 rdata_a", z0_rdata_a, 32'h0);
    check("alias r4 rdata_b", rdata_b, 32'h0);
    check("alias r4 rinit_b", 32'(rinit_b), 32'h0);

    // Back-to-back: toggled data into r1 every edge, port B reading r1 every edge.
    re_a = 1'b0; re_b = 1'b1; raddr_b = 4'd1;
    we = 1'b1; waddr = 4'd1; wbe = 4'b1111;
    d = 32'hA5A50F0F;
    for (int i = 0; i < 6; i++) begin
      wdata = d;
      step();
      check($sformatf("b2b rdata_b %0d", i), rdata_b, d);
      check($sformatf("b2b rvalid_b %0d", i), 32'(rvalid_b), 32'h1);
      d = ~d;
    end
    d = ~d;
    we = 1'b0; re_b = 1'b0;
    step();
    check("b2b hold rdata_b", rdata_b, d);
    check("b2b drop rvalid_b", 32'(rvalid_b), 32'h0);
    check("b2b hold rinit_b", 32'(rinit_b), 32'h1);

    // Asynchronous clear mid-cycle with live read data.
    re_a = 1'b1; raddr_a = 4'd3;
    step();
    check("pre-clear rdata_a", rdata_a, 32'hDEAABE11);
    #3 clr = 1'b1;
    #1;
    check("async clear rdata_a", rdata_a, 32'h0);
    check("async clear rvalid_a", 32'(rvalid_a), 32'h0);
    check("async clear rinit_a", 32'(rinit_a), 32'h0);
    check("async clear rdata_b", rdata_b, 32'h0);
    // Requests while clear is held must be ignored.
    we = 1'b1; waddr = 4'd3; wbe = 4'b1111; wdata = 32'hCAFEF00D;
    step();
    check("held clear rvalid_a", 32'(rvalid_a), 32'h0);
    clr = 1'b0; we = 1'b0;
    re_a = 1'b1; raddr_a = 4'd3; re_b = 1'b1; raddr_b = 4'd5;
    step();
    check("post-clear r3 rdata_a", rdata_a, 32'h0);
    check("post-clear r3 rinit_a", 32'(rinit_a), 32'h0);
    check("post-clear r3 rvalid_a", 32'(rvalid_a), 32'h1);
    check("post-clear r5 rdata_b", rdata_b, 32'h0);
    check("post-clear r5 rinit_b", 32'(rinit_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
